// File: rtl/l2_router_pkg.sv
// Shared types and helpers for the L2 TCDM bank router.
// Optional feature macro (used by the top): L2_ROUTER_ERR_CHECK_EN.
package l2_router_pkg;

  localparam int unsigned NB_BANKS_DEF        = 4;
  localparam int unsigned MAX_OUTSTANDING_DEF = 2;

  // Width of a bank index; never narrower than one bit.
  function automatic int unsigned bank_idx_w(input int unsigned nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

  typedef logic [bank_idx_w(NB_BANKS_DEF)-1:0] bank_idx_t;

endpackage

// File: rtl/l2_router_idx_fifo.sv
// Routing FIFO holding the bank index of each granted transaction, oldest first.
module l2_router_idx_fifo #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rptr];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

  // Pointers wrap modulo DEPTH so non-power-of-two depths work too.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/l2_tcdm_bank_router.sv
// Routes one master onto word-interleaved L2 banks and steers responses back in order.
// Optional macro L2_ROUTER_ERR_CHECK_EN enables the sticky stray-response flag on err_o.
module l2_tcdm_bank_router
  import l2_router_pkg::*;
#(
  parameter int unsigned NB_BANKS        = NB_BANKS_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m_req_i,
  input  logic [31:0]         m_add_i,
  input  logic                m_wen_i,
  input  logic [31:0]         m_wdata_i,
  input  logic [3:0]          m_be_i,
  output logic                m_gnt_o,
  output logic                m_r_valid_o,
  output logic [31:0]         m_r_rdata_o,
  output logic                m_r_opc_o,
  output logic [NB_BANKS-1:0] b_req_o,
  output logic [31:0]         b_add_o   [NB_BANKS],
  output logic [NB_BANKS-1:0] b_wen_o,
  output logic [31:0]         b_wdata_o [NB_BANKS],
  output logic [3:0]          b_be_o    [NB_BANKS],
  input  logic [NB_BANKS-1:0] b_gnt_i,
  input  logic [NB_BANKS-1:0] b_r_valid_i,
  input  logic [31:0]         b_r_rdata_i [NB_BANKS],
  input  logic [NB_BANKS-1:0] b_r_opc_i,
  output logic                err_o
);

  localparam int unsigned IDX_W = bank_idx_w(NB_BANKS);

  logic [IDX_W-1:0] w_sel;
  logic [IDX_W-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_req_ok;
  logic             w_live;

  assign w_sel    = m_add_i[2 +: IDX_W];
  assign w_req_ok = m_req_i & ~w_full & ~rst_i;
  assign w_live   = ~w_empty & ~rst_i;

  assign m_gnt_o     = w_req_ok & b_gnt_i[w_sel];
  assign m_r_valid_o = w_live & b_r_valid_i[w_head];
  assign m_r_rdata_o = w_live ? b_r_rdata_i[w_head] : 32'h0;
  assign m_r_opc_o   = w_live & b_r_opc_i[w_head];

  // Request goes to the selected bank only; payload is broadcast unmodified.
  always_comb begin
    b_req_o = '0;
    if (w_req_ok) b_req_o[w_sel] = 1'b1;
    for (int k = 0; k < NB_BANKS; k++) begin
      b_add_o[k]   = m_add_i;
      b_wen_o[k]   = m_wen_i;
      b_wdata_o[k] = m_wdata_i;
      b_be_o[k]    = m_be_i;
    end
  end

  l2_router_idx_fifo #(
    .DEPTH  (MAX_OUTSTANDING),
    .DATA_W (IDX_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (m_gnt_o),
    .pop_i   (m_r_valid_o),
    .data_i  (w_sel),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

`ifdef L2_ROUTER_ERR_CHECK_EN
  logic [NB_BANKS-1:0] w_exp_rv;
  logic                r_err;

  // Only the head bank may answer; anything else is a stray response.
  always_comb begin
    w_exp_rv = '0;
    if (!w_empty) w_exp_rv[w_head] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                               r_err <= 1'b0;
    else if (|(b_r_valid_i & ~w_exp_rv))     r_err <= 1'b1;
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_l2_tcdm_bank_router.sv
// Directed table-driven bench for l2_tcdm_bank_router (NB_BANKS=4, MAX_OUTSTANDING=2).
module tb_l2_tcdm_bank_router;

`ifdef L2_ROUTER_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int unsigned NB = 4;
  localparam int unsigned NV = 20;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          m_req_i;
  logic [31:0]   m_add_i;
  logic          m_wen_i;
  logic [31:0]   m_wdata_i;
  logic [3:0]    m_be_i;
  logic          m_gnt_o;
  logic          m_r_valid_o;
  logic [31:0]   m_r_rdata_o;
  logic          m_r_opc_o;
  logic [NB-1:0] b_req_o;
  logic [31:0]   b_add_o   [NB];
  logic [NB-1:0] b_wen_o;
  logic [31:0]   b_wdata_o [NB];
  logic [3:0]    b_be_o    [NB];
  logic [NB-1:0] b_gnt_i;
  logic [NB-1:0] b_r_valid_i;
  logic [31:0]   b_r_rdata_i [NB];
  logic [NB-1:0] b_r_opc_i;
  logic          err_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  l2_tcdm_bank_router #(.NB_BANKS(NB), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_req_i(m_req_i), .m_add_i(m_add_i), .m_wen_i(m_wen_i),
    .m_wdata_i(m_wdata_i), .m_be_i(m_be_i),
    .m_gnt_o(m_gnt_o), .m_r_valid_o(m_r_valid_o),
    .m_r_rdata_o(m_r_rdata_o), .m_r_opc_o(m_r_opc_o),
    .b_req_o(b_req_o), .b_add_o(b_add_o), .b_wen_o(b_wen_o),
    .b_wdata_o(b_wdata_o), .b_be_o(b_be_o),
    .b_gnt_i(b_gnt_i), .b_r_valid_i(b_r_valid_i),
    .b_r_rdata_i(b_r_rdata_i), .b_r_opc_i(b_r_opc_i),
    .err_o(err_o)
  );

  typedef struct {
    logic        rst;
    logic        req;
    logic [31:0] add;
    logic [3:0]  gnt;
    logic [3:0]  rv;
    logic [3:0]  opc;
    logic [31:0] base;
    logic [3:0]  e_breq;
    logic        e_gnt;
    logic        e_rv;
    logic [31:0] e_rdata;
    logic        e_opc;
    int          e_cnt;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic rst, input logic req, input logic [31:0] add,
                              input logic [3:0] gnt, input logic [3:0] rv, input logic [3:0] opc,
                              input logic [31:0] base, input logic [3:0] e_breq, input logic e_gnt,
                              input logic e_rv, input logic [31:0] e_rdata, input logic e_opc,
                              input int e_cnt);
    vec_t v;
    v.rst = rst; v.req = req; v.add = add; v.gnt = gnt; v.rv = rv; v.opc = opc;
    v.base = base; v.e_breq = e_breq; v.e_gnt = e_gnt; v.e_rv = e_rv;
    v.e_rdata = e_rdata; v.e_opc = e_opc; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Bank k answers base+k so the returned word reveals which bank was steered.
  task automatic drive_banks(input logic [3:0] rv, input logic [3:0] opc, input logic [31:0] base);
    b_r_valid_i = rv;
    b_r_opc_i   = opc;
    for (int k = 0; k < NB; k++) b_r_rdata_i[k] = base + 32'(k);
  endtask

  initial begin
    vecs[0]  = mk(1, 1, 32'h1C01_0008, 4'hF, 4'hF, 4'h0, 32'h0,         4'b0000, 0, 0, 32'h0,         0, 0);
    vecs[1]  = mk(0, 1, 32'h1C01_0008, 4'hF, 4'h0, 4'h0, 32'h0,         4'b0100, 1, 0, 32'h0,         0, 0);
    vecs[2]  = mk(0, 0, 32'h1C01_0008, 4'hF, 4'h4, 4'h4, 32'hDEAD_BEED, 4'b0000, 0, 1, 32'hDEAD_BEEF, 1, 1);
    vecs[3]  = mk(0, 1, 32'h1C01_0000, 4'hF, 4'h0, 4'h0, 32'h0,         4'b0001, 1, 0, 32'h0,         0, 0);
    vecs[4]  = mk(0, 1, 32'h1C01_0004, 4'hF, 4'h1, 4'h0, 32'h1000,      4'b0010, 1, 1, 32'h1000,      0, 1);
    vecs[5]  = mk(0, 1, 32'h1C01_0008, 4'hF, 4'h2, 4'h2, 32'h2000,      4'b0100, 1, 1, 32'h2001,      1, 1);
    vecs[6]  = mk(0, 1, 32'h1C01_000C, 4'hF, 4'h4, 4'h0, 32'h3000,      4'b1000, 1, 1, 32'h3002,      0, 1);
    vecs[7]  = mk(0, 0, 32'h1C01_000C, 4'hF, 4'h8, 4'h0, 32'h4000,      4'b0000, 0, 1, 32'h4003,      0, 1);
    vecs[8]  = mk(0, 1, 32'h1C01_0004, 4'hD, 4'h0, 4'h0, 32'h0,         4'b0010, 0, 0, 32'h0,         0, 0);
    vecs[9]  = mk(0, 1, 32'h1C01_0004, 4'hD, 4'h0, 4'h0, 32'h0,         4'b0010, 0, 0, 32'h0,         0, 0);
    vecs[10] = mk(0, 1, 32'h1C01_0004, 4'hD, 4'h0, 4'h0, 32'h0,         4'b0010, 0, 0, 32'h0,         0, 0);
    vecs[11] = mk(0, 1, 32'h1C01_0004, 4'hF, 4'h0, 4'h0, 32'h0,         4'b0010, 1, 0, 32'h0,         0, 0);
    vecs[12] = mk(0, 0, 32'h1C01_0004, 4'hF, 4'h2, 4'h0, 32'h5000,      4'b0000, 0, 1, 32'h5001,      0, 1);
    vecs[13] = mk(0, 1, 32'h1C01_0000, 4'hF, 4'h0, 4'h0, 32'h0,         4'b0001, 1, 0, 32'h0,         0, 0);
    vecs[14] = mk(0, 1, 32'h1C01_0008, 4'hF, 4'h0, 4'h0, 32'h6100,      4'b0100, 1, 0, 32'h6100,      0, 1);
    vecs[15] = mk(0, 1, 32'h1C01_000C, 4'hF, 4'h0, 4'h0, 32'h6000,      4'b0000, 0, 0, 32'h6000,      0, 2);
    vecs[16] = mk(0, 1, 32'h1C01_000C, 4'hF, 4'h1, 4'h0, 32'h7000,      4'b0000, 0, 1, 32'h7000,      0, 2);
    vecs[17] = mk(0, 1, 32'h1C01_000C, 4'hF, 4'h0, 4'h0, 32'h8000,      4'b1000, 1, 0, 32'h8002,      0, 1);
    vecs[18] = mk(1, 1, 32'h1C01_0000, 4'hF, 4'h4, 4'h0, 32'h0,         4'b0000, 0, 0, 32'h0,         0, 2);
    vecs[19] = mk(0, 0, 32'h1C01_0000, 4'hF, 4'h4, 4'h4, 32'h9000,      4'b0000, 0, 0, 32'h0,         0, 0);

    rst_i = 1'b1; m_req_i = 1'b0; m_add_i = '0; m_wen_i = 1'b1;
    m_wdata_i = '0; m_be_i = 4'hF; b_gnt_i = '0;
    drive_banks(4'h0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      rst_i = vecs[i].rst; m_req_i = vecs[i].req; m_add_i = vecs[i].add;
      b_gnt_i = vecs[i].gnt;
      drive_banks(vecs[i].rv, vecs[i].opc, vecs[i].base);
      #1;
      chk($sformatf("v%0d b_req", i),   32'(b_req_o),     32'(vecs[i].e_breq));
      chk($sformatf("v%0d m_gnt", i),   32'(m_gnt_o),     32'(vecs[i].e_gnt));
      chk($sformatf("v%0d r_valid", i), 32'(m_r_valid_o), 32'(vecs[i].e_rv));
      chk($sformatf("v%0d r_rdata", i), m_r_rdata_o,      vecs[i].e_rdata);
      chk($sformatf("v%0d r_opc", i),   32'(m_r_opc_o),   32'(vecs[i].e_opc));
      chk($sformatf("v%0d count", i),   32'(dut.u_fifo.r_count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d err", i),     32'(err_o),       32'h0);
      @(posedge clk);
      #1;
    end

    // Payload broadcast to every bank, no request issued.
    rst_i = 1'b0; m_req_i = 1'b0; m_add_i = 32'hA5A5_0004; m_wen_i = 1'b0;
    m_wdata_i = 32'h1234_5678; m_be_i = 4'hA;
    drive_banks(4'h0, 4'h0, 32'h0);
    #1;
    chk("fwd add3",   b_add_o[3],         32'hA5A5_0004);
    chk("fwd wdata1", b_wdata_o[1],       32'h1234_5678);
    chk("fwd be0",    32'(b_be_o[0]),     32'hA);
    chk("fwd wen",    32'(b_wen_o),       32'h0);
    chk("fwd noreq",  32'(b_req_o),       32'h0);

    // Stray response on bank 3 while empty: sticky error when the check is built in.
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    drive_banks(4'h8, 4'h0, 32'h0);
    #1;
    chk("err pre-edge", 32'(err_o), 32'h0);
    chk("stray valid",  32'(m_r_valid_o), 32'h0);
    @(posedge clk); #1;
    drive_banks(4'h0, 4'h0, 32'h0);
    #1;
    chk("err set", 32'(err_o), 32'(ERR_EN));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("err sticky%0d", c), 32'(err_o), 32'(ERR_EN));
    end
    rst_i = 1'b1;
    @(posedge clk); #1;
    chk("err cleared", 32'(err_o), 32'h0);
    rst_i = 1'b0;
    @(posedge clk); #1;
    chk("err stays clear", 32'(err_o), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/l2_tcdm_bank_router.md
L2_TCDM_BANK_ROUTER -- requirements
Module: l2_tcdm_bank_router

Interface
REQ-001 SHALL have parameter NB_BANKS, default 4, meaning the number of interleaved L2 banks (power of two, >=2).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, meaning the routing-FIFO depth (>=2).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have master request ports: m_req_i in 1, m_add_i in 32 (byte address), m_wen_i in 1 (1=read, 0=write), m_wdata_i in 32, m_be_i in 4.
REQ-006 SHALL have master grant and response ports: m_gnt_o out 1, m_r_valid_o out 1, m_r_rdata_o out 32, m_r_opc_o out 1.
REQ-007 SHALL have per-bank request arrays [NB_BANKS]: b_req_o out 1, b_add_o out 32, b_wen_o out 1, b_wdata_o out 32, b_be_o out 4.
REQ-008 SHALL have per-bank response arrays [NB_BANKS]: b_gnt_i in 1, b_r_valid_i in 1, b_r_rdata_i in 32, b_r_opc_i in 1.
REQ-009 SHALL have port err_o  out  1  sticky routing-error flag.

Function
REQ-010 SHALL define bank index sel = m_add_i[2+log2(NB_BANKS)-1:2] (word-interleaved).
REQ-011 SHALL drive b_req_o[sel] = m_req_i & ~full; all other b_req_o SHALL be 0.
REQ-012 SHALL forward m_add_i, m_wen_i, m_wdata_i, m_be_i unmodified and combinationally to every bank (address offset removal belongs to the bank).
REQ-013 SHALL drive m_gnt_o = m_req_i & ~full & b_gnt_i[sel]; request-to-bank path has zero latency.
REQ-014 SHALL push sel into the routing FIFO on every cycle with m_req_i & m_gnt_o, for reads and writes alike.
REQ-015 SHALL drive m_r_valid_o = ~empty & b_r_valid_i[head], m_r_rdata_o = b_r_rdata_i[head], m_r_opc_o = b_r_opc_i[head], head being the FIFO's oldest entry.
REQ-016 SHALL pop the FIFO on every cycle with m_r_valid_o=1.
REQ-017 SHALL treat full as blocking even when a pop occurs in the same cycle (no bypass); simultaneous push and pop when not full SHALL keep the count unchanged.
REQ-018 SHALL sustain one transaction per cycle with MAX_OUTSTANDING>=2 and 1-cycle bank latency.
REQ-019 SHALL wrap read/write pointers modulo MAX_OUTSTANDING; count SHALL be 0..MAX_OUTSTANDING, width $clog2(MAX_OUTSTANDING+1).
REQ-020 SHALL drive m_rdata_o = 0 and m_r_opc_o = 0 when empty.

Reset
REQ-021 SHALL, while rst_i=1, clear FIFO pointers, count and err_o to 0; m_gnt_o, m_r_valid_o, all b_req_o SHALL read 0.
REQ-022 SHALL discard in-flight routing entries on reset mid-operation; bank responses arriving in the cycle after reset release SHALL be ignored (FIFO empty).

Configuration
REQ-023 SHALL, with macro L2_ROUTER_ERR_CHECK_EN defined, set err_o at the next edge when any b_r_valid_i[k] is 1 with k != head or with FIFO empty, holding it until reset.
REQ-024 SHALL, without L2_ROUTER_ERR_CHECK_EN, tie err_o to 0 and omit the check logic.

Structure
REQ-025 SHALL place the bank-index-width function, MAX_OUTSTANDING default and the bank-index typedef in package l2_router_pkg.
REQ-026 SHALL implement the routing FIFO as sub-module l2_router_idx_fifo (push, pop, data, full, empty).

Verification
REQ-027 Bench (NB_BANKS=4) SHALL check: read to 0x1C01_0008 with all b_gnt_i=1 -> b_req_o=4'b0100, m_gnt_o=1; bank 2 returns 0xDEAD_BEEF next cycle -> m_r_valid_o=1, m_r_rdata_o=0xDEAD_BEEF.
REQ-028 SHALL check back-to-back reads to 0x...00,04,08,0C on 4 consecutive cycles -> 4 grants, 4 in-order responses from banks 0,1,2,3 with no bubble.
REQ-029 SHALL check b_gnt_i[1]=0 for 3 cycles with request to 0x...04 -> m_gnt_o=0 for 3 cycles, no FIFO push, grant on cycle 4.
REQ-030 SHALL check responses withheld with 2 outstanding -> full, m_gnt_o=0 while m_req_i=1; one response -> grant resumes next cycle.
REQ-031 SHALL check rst_i asserted with 2 outstanding -> count=0, m_r_valid_o=0, late bank response ignored.
REQ-032 SHALL check with L2_ROUTER_ERR_CHECK_EN: b_r_valid_i[3]=1 while empty -> err_o=1 next cycle and sticky until rst_i.
